// File: rtl/core_inst_seq.sv
// core_inst_seq: drives the 34-bit core instruction word through one layer pass.
// For each kernel index: weight fetch, weight load, propagation wait, activation
// fetch, execute, then drain of the ofifo into psum SRAM. After the last kernel
// index, psum rows are read out into the SFP for accumulation.
//
// Ports:
//   clk          clock
//   reset        synchronous active-low reset
//   start        one-cycle pulse, accepted only when idle
//   w_base       xmem base of weights (kernel k uses w_base + k*col)
//   x_base       xmem base of activations
//   psum_base    psum SRAM base
//   n_kij        kernel positions per pass (0 means an empty pass)
//   n_nij        output pixels per kernel position (0 means an empty pass)
//   ofifo_valid  ofifo holds a full row (only looked at while draining)
//   inst         registered instruction word
//   busy         high while a pass is in flight
//   done         one-cycle pulse at the end of a pass
//
// Each clock edge issues the word the core sees during the following cycle, so
// state_q/cnt_q always name the step that is about to be issued.
module core_inst_seq #(
  parameter int unsigned col       = 8,
  parameter int unsigned row       = 8,
  parameter int unsigned LOAD_WAIT = row + col,
  parameter int unsigned AW        = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] psum_base,
  input  logic [3:0]    n_kij,
  input  logic [6:0]    n_nij,
  input  logic          ofifo_valid,
  output logic [33:0]   inst,
  output logic          busy,
  output logic          done
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StWFetch = 4'd1;
  localparam logic [3:0] StWLoad  = 4'd2;
  localparam logic [3:0] StWWait  = 4'd3;
  localparam logic [3:0] StXFetch = 4'd4;
  localparam logic [3:0] StExec   = 4'd5;
  localparam logic [3:0] StDrain  = 4'd6;
  localparam logic [3:0] StAcc    = 4'd7;
  localparam logic [3:0] StDone   = 4'd8;

  localparam logic [33:0] IdleWord = 34'h1_800C_0000;
  localparam logic [7:0]  ColCnt   = 8'(col);
  localparam logic [7:0]  ColLast  = 8'(col - 1);
  localparam logic [7:0]  WaitLast = 8'(LOAD_WAIT - 1);

  logic [3:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    nk_q, nk_d;
  logic [6:0]    nn_q, nn_d;
  logic [AW-1:0] xb_q, xb_d;
  logic [AW-1:0] pb_q, pb_d;
  logic [AW-1:0] wk_q, wk_d;          // w_base + k*col
  logic [AW-1:0] pk_q, pk_d;          // psum_base + k*n_nij
  logic [AW-1:0] acc_row_q, acc_row_d;  // psum_base + o
  logic [AW-1:0] acc_addr_q, acc_addr_d;
  logic [33:0]   inst_q, inst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          sfp, p_cen, p_wen, x_cen, x_wen;
  logic [AW-1:0] p_a, x_a;
  logic [6:0]    ctl;
  logic [7:0]    nn_cnt;

  assign nn_cnt = {1'b0, nn_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    nk_d       = nk_q;
    nn_d       = nn_q;
    xb_d       = xb_q;
    pb_d       = pb_q;
    wk_d       = wk_q;
    pk_d       = pk_q;
    acc_row_d  = acc_row_q;
    acc_addr_d = acc_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sfp        = 1'b0;
    p_cen      = 1'b1;
    p_wen      = 1'b1;
    p_a        = '0;
    x_cen      = 1'b1;
    x_wen      = 1'b1;
    x_a        = '0;
    ctl        = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (n_kij == 4'd0 || n_nij == 7'd0) begin
            done_d = 1'b1;
          end else begin
            nk_d    = n_kij;
            nn_d    = n_nij;
            xb_d    = x_base;
            pb_d    = psum_base;
            wk_d    = w_base;
            pk_d    = psum_base;
            k_d     = '0;
            busy_d  = 1'b1;
            // Issue the first weight read straight away from the live inputs.
            x_cen   = 1'b0;
            x_a     = w_base;
            cnt_d   = 8'd1;
            state_d = StWFetch;
          end
        end
      end

      StWFetch: begin
        if (cnt_q < ColCnt) begin
          x_cen = 1'b0;
          x_a   = wk_q + AW'(cnt_q);
        end
        // L0 write trails the read by one cycle for the SRAM read latency.
        if (cnt_q != 8'd0) ctl[2] = 1'b1;
        if (cnt_q == ColCnt) begin
          cnt_d   = '0;
          state_d = StWLoad;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StWLoad: begin
        ctl[3] = 1'b1;
        ctl[0] = 1'b1;
        if (cnt_q == ColLast) begin
          cnt_d   = '0;
          state_d = StWWait;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StWWait: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = '0;
          state_d = StXFetch;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StXFetch: begin
        if (cnt_q < nn_cnt) begin
          x_cen = 1'b0;
          x_a   = xb_q + AW'(cnt_q);
        end
        if (cnt_q != 8'd0) ctl[5] = 1'b1;
        if (cnt_q == nn_cnt) begin
          cnt_d   = '0;
          state_d = StExec;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StExec: begin
        ctl[4] = 1'b1;
        ctl[1] = 1'b1;
        if (cnt_q == nn_cnt - 8'd1) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StDrain: begin
        // ofifo data is the psum write data, so read and write share a word.
        if (ofifo_valid) begin
          ctl[6] = 1'b1;
          p_cen  = 1'b0;
          p_wen  = 1'b0;
          p_a    = pk_q + AW'(cnt_q);
          if (cnt_q == nn_cnt - 8'd1) begin
            cnt_d = '0;
            if (k_q == nk_q - 4'd1) begin
              k_d        = '0;
              acc_row_d  = pb_q;
              acc_addr_d = pb_q;
              state_d    = StAcc;
            end else begin
              k_d     = k_q + 4'd1;
              wk_d    = wk_q + AW'(col);
              pk_d    = pk_q + AW'(nn_q);
              state_d = StWFetch;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      StAcc: begin
        // cnt_q is the output pixel o (outer), k_q the kernel index (inner).
        // sfp_valid marks the data of the read issued one cycle earlier.
        sfp = !(cnt_q == 8'd0 && k_q == 4'd0);
        if (cnt_q < nn_cnt) begin
          p_cen = 1'b0;
          p_a   = acc_addr_q;
          if (k_q == nk_q - 4'd1) begin
            k_d        = '0;
            cnt_d      = cnt_q + 8'd1;
            acc_row_d  = acc_row_q + AW'(1);
            acc_addr_d = acc_row_q + AW'(1);
          end else begin
            k_d        = k_q + 4'd1;
            acc_addr_d = acc_addr_q + AW'(nn_q);
          end
        end else begin
          state_d = StDone;
        end
      end

      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    inst_d = {sfp, p_cen, p_wen, p_a, x_cen, x_wen, x_a, ctl};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      k_q        <= '0;
      nk_q       <= '0;
      nn_q       <= '0;
      xb_q       <= '0;
      pb_q       <= '0;
      wk_q       <= '0;
      pk_q       <= '0;
      acc_row_q  <= '0;
      acc_addr_q <= '0;
      inst_q     <= IdleWord;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      nk_q       <= nk_d;
      nn_q       <= nn_d;
      xb_q       <= xb_d;
      pb_q       <= pb_d;
      wk_q       <= wk_d;
      pk_q       <= pk_d;
      acc_row_q  <= acc_row_d;
      acc_addr_q <= acc_addr_d;
      inst_q     <= inst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq. A pass model expands the layer schedule
// into a per-cycle list of expected (inst, busy, done) records tagged with the
// absolute cycle they belong to; a monitor compares the DUT on every negedge,
// expecting the idle word whenever no record is due.
module tb_core_inst_seq;

  localparam int COL = 8;
  localparam int LW  = 16;
  localparam logic [33:0] IDLE = 34'h1_800C_0000;

  typedef struct {
    int          cyc;
    logic [33:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, psum_base = '0;
  logic [3:0]  n_kij = '0;
  logic [6:0]  n_nij = '0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        busy, done;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   vpat [0:2047];
  exp_t exp_q[$];
  exp_t me;

  core_inst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .w_base     (w_base),
    .x_base     (x_base),
    .psum_base  (psum_base),
    .n_kij      (n_kij),
    .n_nij      (n_nij),
    .ofifo_valid(ofifo_valid),
    .inst       (inst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [33:0] mk(input bit sfp, input bit pcen, input bit pwen, input int pa,
                                     input bit xcen, input int xa, input logic [6:0] ctl);
    logic [33:0] w;
    int pm, xm;
    pm = pa % 2048;
    xm = xa % 2048;
    w = '0;
    w[33]    = sfp;
    w[32]    = pcen;
    w[31]    = pwen;
    w[30:20] = pm[10:0];
    w[19]    = xcen;
    w[18]    = 1'b1;
    w[17:7]  = xm[10:0];
    w[6:0]   = ctl;
    return w;
  endfunction

  task automatic push(input int c, input logic [33:0] w, input bit b, input bit d);
    exp_t e;
    e.cyc = c; e.inst = w; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  // Expected schedule of one pass; output cycle m of the pass is cycle c+m.
  // A drain step in cycle m acts on the ofifo_valid level seen in cycle m-1.
  task automatic model_pass(input int c, input int wb, input int xb, input int pb,
                            input int nk, input int nn, output int len);
    int m, j;
    bit first;
    m = 1;
    if (nk == 0 || nn == 0) begin
      push(c + m, IDLE, 1'b0, 1'b1);
      m++;
    end else begin
      for (int k = 0; k < nk; k++) begin
        for (int i = 0; i <= COL; i++) begin
          push(c + m, mk(0, 1, 1, 0, (i < COL) ? 0 : 1, (i < COL) ? wb + k * COL + i : 0,
                         (i >= 1) ? 7'h04 : 7'h00), 1'b1, 1'b0);
          m++;
        end
        for (int i = 0; i < COL; i++) begin push(c + m, mk(0, 1, 1, 0, 1, 0, 7'h09), 1, 0); m++; end
        for (int i = 0; i < LW; i++) begin push(c + m, IDLE, 1'b1, 1'b0); m++; end
        for (int i = 0; i <= nn; i++) begin
          push(c + m, mk(0, 1, 1, 0, (i < nn) ? 0 : 1, (i < nn) ? xb + i : 0,
                         (i >= 1) ? 7'h20 : 7'h00), 1'b1, 1'b0);
          m++;
        end
        for (int i = 0; i < nn; i++) begin push(c + m, mk(0, 1, 1, 0, 1, 0, 7'h12), 1, 0); m++; end
        j = 0;
        while (j < nn && m < 2000) begin
          if (vpat[m-1]) begin
            push(c + m, mk(0, 0, 0, pb + k * nn + j, 1, 0, 7'h40), 1'b1, 1'b0);
            j++;
          end else begin
            push(c + m, IDLE, 1'b1, 1'b0);
          end
          m++;
        end
      end
      first = 1'b1;
      for (int o = 0; o < nn; o++) begin
        for (int k = 0; k < nk; k++) begin
          push(c + m, mk(!first, 0, 1, pb + k * nn + o, 1, 0, 7'h00), 1'b1, 1'b0);
          first = 1'b0;
          m++;
        end
      end
      push(c + m, mk(1, 1, 1, 0, 1, 0, 7'h00), 1'b1, 1'b0); m++;
      push(c + m, IDLE, 1'b0, 1'b1); m++;
    end
    len = m - 1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // mode: 0 valid always high, 1 repeating 1,0,0, 2 random.
  // restart_at / reset_at: output cycle of the pass at which to pulse start or reset.
  task automatic run_pass(input int wb, input int xb, input int pb, input int nk, input int nn,
                          input int mode, input int restart_at, input int reset_at);
    int c, len;
    for (int i = 0; i < 2048; i++) begin
      case (mode)
        0:       vpat[i] = 1'b1;
        1:       vpat[i] = (i % 3 == 0);
        default: vpat[i] = ($urandom_range(0, 2) != 0);
      endcase
    end
    c = cyc;
    w_base = 11'(wb); x_base = 11'(xb); psum_base = 11'(pb);
    n_kij = 4'(nk); n_nij = 7'(nn);
    start = 1'b1;
    ofifo_valid = vpat[0];
    model_pass(c, wb, xb, pb, nk, nn, len);
    for (int m = 1; m <= len + 2; m++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ofifo_valid = vpat[m];
      if (m == restart_at) begin
        start = 1'b1;
        w_base = 11'($urandom_range(0, 2047));
        x_base = 11'($urandom_range(0, 2047));
        n_kij = 4'd5;
      end
      if (m == reset_at) begin
        reset = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > c + m) void'(exp_q.pop_back());
        @(posedge clk); #1;
        reset = 1'b1;
        break;
      end
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        me = exp_q.pop_front();
      end else begin
        me.cyc = cyc; me.inst = IDLE; me.busy = 1'b0; me.done = 1'b0;
      end
      checks++;
      if (inst !== me.inst) begin
        failures++;
        $display("FAIL inst cyc=%0d got=%h want=%h", cyc, inst, me.inst);
      end
      checks++;
      if (busy !== me.busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, me.busy);
      end
      checks++;
      if (done !== me.done) begin
        failures++;
        $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, me.done);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with start asserted.
    reset = 1'b0;
    start = 1'b1;
    n_kij = 4'd1; n_nij = 7'd4;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle_cycles(3);
    start = 1'b0;
    reset = 1'b1;
    idle_cycles(2);

    run_pass(0, 16, 0, 1, 4, 0, -1, -1);       // single kij
    idle_cycles(3);
    run_pass(0, 16, 0, 1, 4, 1, -1, -1);       // drain stalls
    idle_cycles(3);
    run_pass(40, 200, 100, 3, 2, 0, -1, -1);   // multi kij, interleaved readout
    idle_cycles(3);
    run_pass(0, 16, 0, 1, 0, 0, -1, -1);       // n_nij == 0
    idle_cycles(2);
    run_pass(0, 16, 0, 0, 3, 0, -1, -1);       // n_kij == 0
    idle_cycles(2);
    run_pass(8, 32, 50, 2, 3, 2, 20, -1);      // start while busy
    idle_cycles(3);
    run_pass(2044, 2045, 2046, 1, 4, 0, -1, -1);  // address wrap
    idle_cycles(3);
    run_pass(0, 16, 0, 1, 4, 0, -1, 40);       // reset during execute
    idle_cycles(2);
    run_pass(0, 16, 0, 1, 4, 0, -1, -1);       // clean pass after abort
    idle_cycles(3);
    for (int t = 0; t < 4; t++) begin
      run_pass($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
               $urandom_range(1, 3), $urandom_range(1, 6), 2, -1, -1);
      idle_cycles(2);
    end
    idle_cycles(5);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
